// File: rtl/hpdcache_pkg.sv
// HPDcache core-request interface types shared by requesters and responders.
// Field layout is the subset needed by the scratchpad responder and its adapters.
package hpdcache_pkg;

    localparam int HPDCACHE_PA_WIDTH         = 64;
    localparam int HPDCACHE_REQ_OFFSET_WIDTH = 12;
    localparam int HPDCACHE_TAG_WIDTH        = HPDCACHE_PA_WIDTH - HPDCACHE_REQ_OFFSET_WIDTH;
    localparam int HPDCACHE_REQ_DATA_WIDTH   = 64;
    localparam int HPDCACHE_REQ_BE_WIDTH     = HPDCACHE_REQ_DATA_WIDTH / 8;
    localparam int HPDCACHE_REQ_SID_WIDTH    = 3;
    localparam int HPDCACHE_REQ_TID_WIDTH    = 6;

    typedef logic [HPDCACHE_REQ_OFFSET_WIDTH-1:0] hpdcache_req_offset_t;
    typedef logic [HPDCACHE_TAG_WIDTH-1:0]        hpdcache_tag_t;
    typedef logic [HPDCACHE_REQ_DATA_WIDTH-1:0]   hpdcache_req_data_t;
    typedef logic [HPDCACHE_REQ_BE_WIDTH-1:0]     hpdcache_req_be_t;
    typedef logic [2:0]                           hpdcache_req_size_t;
    typedef logic [HPDCACHE_REQ_SID_WIDTH-1:0]    hpdcache_req_sid_t;
    typedef logic [HPDCACHE_REQ_TID_WIDTH-1:0]    hpdcache_req_tid_t;

    typedef enum logic [3:0] {
        HPDCACHE_REQ_LOAD     = 4'h0,
        HPDCACHE_REQ_STORE    = 4'h1,
        HPDCACHE_REQ_AMO_LR   = 4'h4,
        HPDCACHE_REQ_AMO_SC   = 4'h5,
        HPDCACHE_REQ_AMO_SWAP = 4'h6,
        HPDCACHE_REQ_AMO_ADD  = 4'h7,
        HPDCACHE_REQ_AMO_AND  = 4'h8,
        HPDCACHE_REQ_AMO_OR   = 4'h9,
        HPDCACHE_REQ_AMO_XOR  = 4'ha,
        HPDCACHE_REQ_AMO_MAX  = 4'hb,
        HPDCACHE_REQ_AMO_MAXU = 4'hc,
        HPDCACHE_REQ_AMO_MIN  = 4'hd,
        HPDCACHE_REQ_AMO_MINU = 4'he
    } hpdcache_req_op_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        hpdcache_req_offset_t addr_offset;
        hpdcache_req_data_t   wdata;
        hpdcache_req_op_t     op;
        hpdcache_req_be_t     be;
        hpdcache_req_size_t   size;
        hpdcache_req_sid_t    sid;
        hpdcache_req_tid_t    tid;
        logic                 need_rsp;
        logic                 phys_indexed;
        hpdcache_tag_t        addr_tag;
        hpdcache_pma_t        pma;
    } hpdcache_req_t;

    typedef struct packed {
        hpdcache_req_data_t rdata;
        hpdcache_req_sid_t  sid;
        hpdcache_req_tid_t  tid;
        logic               error;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hpdcache_spad_pkg.sv
// Scratchpad-responder types: storage word, word index, reservation and pipeline registers.
package hpdcache_spad_pkg;

    // Index type is sized for the largest supported scratchpad; instances slice it to $clog2(DEPTH).
    localparam int SPAD_IDX_W = 16;

    typedef logic [63:0]           spad_word_t;
    typedef logic [SPAD_IDX_W-1:0] spad_idx_t;

    typedef struct packed {
        logic      valid;
        spad_idx_t idx;
    } spad_resv_t;

    typedef struct packed {
        logic                             valid;
        hpdcache_pkg::hpdcache_req_op_t   op;
        spad_idx_t                        idx;
        hpdcache_pkg::hpdcache_req_be_t   be;
        hpdcache_pkg::hpdcache_req_size_t size;
        spad_word_t                       wdata;
        hpdcache_pkg::hpdcache_req_sid_t  sid;
        hpdcache_pkg::hpdcache_req_tid_t  tid;
        logic                             need_rsp;
        logic                             error;
    } spad_pipe_t;

    function automatic logic spad_is_amo(hpdcache_pkg::hpdcache_req_op_t op);
        return op inside {hpdcache_pkg::HPDCACHE_REQ_AMO_SWAP, hpdcache_pkg::HPDCACHE_REQ_AMO_ADD,
                          hpdcache_pkg::HPDCACHE_REQ_AMO_AND,  hpdcache_pkg::HPDCACHE_REQ_AMO_OR,
                          hpdcache_pkg::HPDCACHE_REQ_AMO_XOR,  hpdcache_pkg::HPDCACHE_REQ_AMO_MAX,
                          hpdcache_pkg::HPDCACHE_REQ_AMO_MAXU, hpdcache_pkg::HPDCACHE_REQ_AMO_MIN,
                          hpdcache_pkg::HPDCACHE_REQ_AMO_MINU};
    endfunction

    function automatic logic spad_is_atomic(hpdcache_pkg::hpdcache_req_op_t op);
        return spad_is_amo(op) || (op == hpdcache_pkg::HPDCACHE_REQ_AMO_LR)
                               || (op == hpdcache_pkg::HPDCACHE_REQ_AMO_SC);
    endfunction

    function automatic spad_word_t spad_merge_be(spad_word_t old_w, spad_word_t new_w,
                                                 hpdcache_pkg::hpdcache_req_be_t be);
        spad_word_t r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hpdcache_spad_amo_alu.sv
// Combinational AMO ALU: computes the word written back by an atomic read-modify-write.
// 32-bit operations act on the lane chosen by the upper byte enables; the other lane is kept.
module hpdcache_spad_amo_alu
    import hpdcache_pkg::*;
    import hpdcache_spad_pkg::*;
(
    input  spad_word_t         old_word,
    input  spad_word_t         operand,
    input  hpdcache_req_op_t   op,
    input  hpdcache_req_size_t size,
    input  hpdcache_req_be_t   be,
    output spad_word_t         new_word
);

    logic        lane_hi;
    logic [31:0] a32, b32, r32;
    spad_word_t  r64;
    logic        unused_be;

    assign unused_be = ^be[3:0];

    always_comb begin
        lane_hi = |be[7:4];
        a32     = lane_hi ? old_word[63:32] : old_word[31:0];
        b32     = lane_hi ? operand[63:32]  : operand[31:0];
        r64     = old_word;
        r32     = a32;
        case (op)
            HPDCACHE_REQ_AMO_SWAP: begin r64 = operand;             r32 = b32;       end
            HPDCACHE_REQ_AMO_ADD:  begin r64 = old_word + operand;  r32 = a32 + b32; end
            HPDCACHE_REQ_AMO_AND:  begin r64 = old_word & operand;  r32 = a32 & b32; end
            HPDCACHE_REQ_AMO_OR:   begin r64 = old_word | operand;  r32 = a32 | b32; end
            HPDCACHE_REQ_AMO_XOR:  begin r64 = old_word ^ operand;  r32 = a32 ^ b32; end
            HPDCACHE_REQ_AMO_MAX: begin
                r64 = ($signed(old_word) > $signed(operand)) ? old_word : operand;
                r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
            end
            HPDCACHE_REQ_AMO_MAXU: begin
                r64 = (old_word > operand) ? old_word : operand;
                r32 = (a32 > b32) ? a32 : b32;
            end
            HPDCACHE_REQ_AMO_MIN: begin
                r64 = ($signed(old_word) < $signed(operand)) ? old_word : operand;
                r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
            end
            HPDCACHE_REQ_AMO_MINU: begin
                r64 = (old_word < operand) ? old_word : operand;
                r32 = (a32 < b32) ? a32 : b32;
            end
            default: ;
        endcase

        new_word = old_word;
        if (size == 3'd3)  new_word = r64;
        else if (lane_hi)  new_word[63:32] = r32;
        else               new_word[31:0]  = r32;
    end

endmodule

// File: rtl/hpdcache_req_spad_responder.sv
// Responder end of the HPDcache core-request interface, serving requests from a local scratchpad.
// Two stages: S1 resolves the late tag/abort, reads the array and commits stores; S2 drives the response.
module hpdcache_req_spad_responder
    import hpdcache_pkg::*;
    import hpdcache_spad_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0
)(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  hpdcache_req_t req_i,
    input  logic          req_abort_i,
    input  hpdcache_tag_t req_tag_i,
    input  hpdcache_pma_t req_pma_i,
    output logic          rsp_valid_o,
    output hpdcache_rsp_t rsp_o
);

    localparam int IW = $clog2(DEPTH);

    logic          busy;
    logic          req_accept;
    logic          s1_valid;
    hpdcache_req_t s1_req;
    spad_pipe_t    s2;
    spad_word_t    s2_rdata;
    spad_resv_t    resv, resv_next;
    spad_word_t    mem [DEPTH];

    logic [63:0]   s1_addr, s1_off;
    logic          s1_live, s1_oob, s1_resv_hit, s1_we, s1_send;
    spad_idx_t     s1_idx;
    spad_word_t    s1_word, s1_rdata, s1_merged;
    logic          amo_we;
    spad_word_t    amo_word;
    logic          unused_ok;

    assign unused_ok   = ^{req_pma_i, s1_req.pma, s2.idx, s1_off[2:0]};
    assign req_ready_o = !busy;
    assign req_accept  = req_valid_i && req_ready_o;

    // S1 address resolution: virtually indexed requests take their tag (or a kill) one cycle late.
    always_comb begin
        s1_addr     = s1_req.phys_indexed ? {s1_req.addr_tag, s1_req.addr_offset}
                                          : {req_tag_i, s1_req.addr_offset};
        s1_live     = s1_valid && !(!s1_req.phys_indexed && req_abort_i);
        s1_off      = s1_addr - BASE_ADDR;
        s1_oob      = (s1_addr < BASE_ADDR) || ({3'b000, s1_off[63:3]} >= 64'(DEPTH));
        s1_idx      = s1_off[SPAD_IDX_W+2:3];
        s1_word     = mem[s1_idx[IW-1:0]];
        s1_resv_hit = resv.valid && (resv.idx == s1_idx);
        s1_merged   = spad_merge_be(s1_word, s1_req.wdata, s1_req.be);
    end

    // S1 decode: what gets written now, what is returned, and how the reservation moves.
    always_comb begin
        s1_we     = 1'b0;
        s1_rdata  = s1_word;
        s1_send   = 1'b1;
        resv_next = resv;
        case (s1_req.op)
            HPDCACHE_REQ_STORE: begin
                s1_we    = !s1_oob;
                s1_rdata = '0;
                s1_send  = s1_req.need_rsp;
                if (s1_resv_hit) resv_next.valid = 1'b0;
            end
            HPDCACHE_REQ_AMO_LR: begin
                s1_send = s1_req.need_rsp;
                if (!s1_oob) resv_next = '{valid: 1'b1, idx: s1_idx};
            end
            HPDCACHE_REQ_AMO_SC: begin
                s1_we           = s1_resv_hit && !s1_oob;
                s1_rdata        = s1_we ? 64'd0 : 64'd1;
                s1_send         = s1_req.need_rsp;
                resv_next.valid = 1'b0;
            end
            default: begin
                if (spad_is_amo(s1_req.op)) begin
                    s1_send = s1_req.need_rsp;
                    if (s1_resv_hit) resv_next.valid = 1'b0;
                end
            end
        endcase
        if (s1_oob) s1_rdata = '0;
        if (!s1_live) resv_next = resv;
    end

    // Handshake and pipeline registers; atomics hold ready low for the cycle after acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy     <= 1'b0;
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s2       <= '0;
            s2_rdata <= '0;
            resv     <= '0;
        end else begin
            busy     <= req_accept && spad_is_atomic(req_i.op);
            s1_valid <= req_accept;
            if (req_accept) s1_req <= req_i;
            resv     <= resv_next;
            s2.valid <= s1_live;
            if (s1_live) begin
                s2.op       <= s1_req.op;
                s2.idx      <= s1_idx;
                s2.be       <= s1_req.be;
                s2.size     <= s1_req.size;
                s2.wdata    <= s1_req.wdata;
                s2.sid      <= s1_req.sid;
                s2.tid      <= s1_req.tid;
                s2.need_rsp <= s1_send;
                s2.error    <= s1_oob;
                s2_rdata    <= s1_rdata;
            end
        end
    end

    hpdcache_spad_amo_alu u_amo_alu (
        .old_word (s2_rdata),
        .operand  (s2.wdata),
        .op       (s2.op),
        .size     (s2.size),
        .be       (s2.be),
        .new_word (amo_word)
    );

    assign amo_we = s2.valid && !s2.error && spad_is_amo(s2.op);

    // Storage is not reset; the S2 AMO write and the S1 store/SC write never coincide because of busy.
    always_ff @(posedge clk_i) begin
        if (amo_we)                mem[s2.idx[IW-1:0]] <= amo_word;
        else if (s1_live && s1_we) mem[s1_idx[IW-1:0]] <= s1_merged;
    end

    always_comb begin
        rsp_valid_o = s2.valid && s2.need_rsp;
        rsp_o.rdata = s2_rdata;
        rsp_o.sid   = s2.sid;
        rsp_o.tid   = s2.tid;
        rsp_o.error = s2.error;
    end

endmodule

// File: tb/tb_hpdcache_req_spad_responder.sv
// Scoreboard bench for the scratchpad responder: directed requests push expected responses,
// a negedge monitor pops and compares data, metadata and arrival cycle.
module tb_hpdcache_req_spad_responder;
    import hpdcache_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    hpdcache_req_t req_i;
    logic          req_abort_i;
    hpdcache_tag_t req_tag_i;
    hpdcache_pma_t req_pma_i;
    logic          rsp_valid_o;
    hpdcache_rsp_t rsp_o;

    localparam logic [2:0] SID = 3'd2;

    typedef struct {
        logic [63:0] rdata;
        logic [5:0]  tid;
        logic        error;
        int          due;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    hpdcache_req_spad_responder #(.DEPTH(256), .BASE_ADDR(64'h0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_i       (req_i),
        .req_abort_i (req_abort_i),
        .req_tag_i   (req_tag_i),
        .req_pma_i   (req_pma_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_o       (rsp_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rsp_valid_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp actual tid=%0d rdata=%0h required=no response",
                         rsp_o.tid, rsp_o.rdata);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_rdata",   rsp_o.rdata, e.rdata);
                checkOutput("rsp_meta",    {rsp_o.sid, rsp_o.tid, rsp_o.error}, {SID, e.tid, e.error});
                checkOutput("rsp_latency", 128'(cyc), 128'(e.due));
            end
        end
    end

    // Issues one request starting at a negedge; returns at the negedge of cycle N+1 after
    // driving the late tag/abort for it, so a following call lands back-to-back.
    task automatic applyStimulus(input hpdcache_req_op_t op, input int idx, input logic [63:0] wdata,
                                 input logic [7:0] be, input logic [2:0] size, input logic [5:0] tid,
                                 input logic need_rsp, input logic phys, input logic abort,
                                 input logic expect_rsp, input logic [63:0] exp_rdata, input logic exp_err);
        logic [63:0] addr;
        int          waitCyc;
        addr    = 64'(idx) << 3;
        waitCyc = 0;
        req_valid_i        = 1'b1;
        req_i              = '0;
        req_i.addr_offset  = addr[11:0];
        req_i.addr_tag     = phys ? addr[63:12] : 52'hABCDE;
        req_i.wdata        = wdata;
        req_i.op           = op;
        req_i.be           = be;
        req_i.size         = size;
        req_i.sid          = SID;
        req_i.tid          = tid;
        req_i.need_rsp     = need_rsp;
        req_i.phys_indexed = phys;
        while (req_ready_o !== 1'b1 && waitCyc < 8) begin
            @(negedge clk_i);
            waitCyc++;
        end
        if (req_ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout actual ready=%b required=1 tid=%0d", req_ready_o, tid);
            req_valid_i = 1'b0;
            return;
        end
        if (expect_rsp) expQ.push_back('{exp_rdata, tid, exp_err, cyc + 2});
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_tag_i   = addr[63:12];
        req_abort_i = abort;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
        req_abort_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_i       = '0;
        req_abort_i = 1'b0;
        req_tag_i   = '0;
        req_pma_i   = '0;
        #1 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_rsp_valid", rsp_valid_o, 1'b0);
        checkOutput("reset_rsp",       rsp_o, '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_ready", req_ready_o, 1'b1);

        // store then back-to-back load, plus an unrecognised op behaving as a load
        applyStimulus(HPDCACHE_REQ_STORE, 5, 64'hDEAD_BEEF_0123_4567, 8'hff, 3, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,  5, 64'h0, 8'hff, 3, 3, 1, 1, 0, 1, 64'hDEAD_BEEF_0123_4567, 0);
        applyStimulus(hpdcache_req_op_t'(4'hf), 5, 64'h0, 8'hff, 3, 9, 1, 1, 0, 1, 64'hDEAD_BEEF_0123_4567, 0);
        idle(2);

        // virtually indexed: aborted, then completed with the late tag
        applyStimulus(HPDCACHE_REQ_LOAD, 5, 64'h0, 8'hff, 3, 4, 1, 0, 1, 0, 0, 0);
        checkOutput("ready_after_abort", req_ready_o, 1'b1);
        idle(3);
        applyStimulus(HPDCACHE_REQ_LOAD, 5, 64'h0, 8'hff, 3, 5, 1, 0, 0, 1, 64'hDEAD_BEEF_0123_4567, 0);

        // AMOs on word 7
        applyStimulus(HPDCACHE_REQ_STORE,   7, 64'h0000_0005_FFFF_FFFF, 8'hff, 3, 6, 1, 1, 0, 1, 64'h0, 0);
        applyStimulus(HPDCACHE_REQ_AMO_ADD, 7, 64'h0000_0001_0000_0001, 8'hf0, 2, 7, 1, 1, 0, 1, 64'h0000_0005_FFFF_FFFF, 0);
        checkOutput("ready_amo_n1", req_ready_o, 1'b0);
        applyStimulus(HPDCACHE_REQ_LOAD,     7, 64'h0, 8'hff, 3, 8, 1, 1, 0, 1, 64'h0000_0006_FFFF_FFFF, 0);
        applyStimulus(HPDCACHE_REQ_AMO_ADD,  7, 64'h1, 8'hff, 3, 11, 1, 1, 0, 1, 64'h0000_0006_FFFF_FFFF, 0);
        applyStimulus(HPDCACHE_REQ_AMO_MAXU, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0f, 2, 12, 1, 1, 0, 1, 64'h0000_0007_0000_0000, 0);
        applyStimulus(HPDCACHE_REQ_AMO_MIN,  7, 64'h0000_0003_0000_0003, 8'h0f, 2, 13, 1, 1, 0, 1, 64'h0000_0007_FFFF_FFFF, 0);
        applyStimulus(HPDCACHE_REQ_AMO_MAX,  7, 64'h0000_0003_0000_0003, 8'h0f, 2, 14, 1, 1, 0, 1, 64'h0000_0007_FFFF_FFFF, 0);
        applyStimulus(HPDCACHE_REQ_AMO_XOR,  7, 64'hFFFF_0000_0000_0000, 8'hff, 3, 15, 0, 1, 0, 0, 0, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,     7, 64'h0, 8'hff, 3, 16, 1, 1, 0, 1, 64'hFFFF_0007_0000_0003, 0);

        // LR/SC reservation on word 9
        applyStimulus(HPDCACHE_REQ_STORE,  9, 64'h1111_2222_3333_4444, 8'hff, 3, 17, 0, 1, 0, 0, 0, 0);
        applyStimulus(HPDCACHE_REQ_AMO_LR, 9, 64'h0, 8'hff, 3, 18, 1, 1, 0, 1, 64'h1111_2222_3333_4444, 0);
        applyStimulus(HPDCACHE_REQ_STORE,  9, 64'hAAAA_BBBB_5555_6666, 8'h0f, 3, 19, 0, 1, 0, 0, 0, 0);
        applyStimulus(HPDCACHE_REQ_AMO_SC, 9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hff, 3, 20, 1, 1, 0, 1, 64'h1, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,   9, 64'h0, 8'hff, 3, 21, 1, 1, 0, 1, 64'h1111_2222_5555_6666, 0);
        applyStimulus(HPDCACHE_REQ_AMO_LR, 9, 64'h0, 8'hff, 3, 22, 1, 1, 0, 1, 64'h1111_2222_5555_6666, 0);
        applyStimulus(HPDCACHE_REQ_AMO_SC, 9, 64'h0BAD_F00D_0000_0001, 8'hff, 3, 23, 1, 1, 0, 1, 64'h0, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,   9, 64'h0, 8'hff, 3, 24, 1, 1, 0, 1, 64'h0BAD_F00D_0000_0001, 0);
        applyStimulus(HPDCACHE_REQ_AMO_SC, 9, 64'h0123_0123_0123_0123, 8'hff, 3, 25, 1, 1, 0, 1, 64'h1, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,   9, 64'h0, 8'hff, 3, 26, 1, 1, 0, 1, 64'h0BAD_F00D_0000_0001, 0);

        // out of range: index DEPTH aliases word 0 if the range check is missing
        applyStimulus(HPDCACHE_REQ_STORE, 0,   64'h0000_0000_0000_00AA, 8'hff, 3, 27, 0, 1, 0, 0, 0, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,  256, 64'h0, 8'hff, 3, 28, 1, 1, 0, 1, 64'h0, 1);
        applyStimulus(HPDCACHE_REQ_STORE, 256, 64'hFFFF_FFFF_FFFF_FFFF, 8'hff, 3, 29, 1, 1, 0, 1, 64'h0, 1);
        applyStimulus(HPDCACHE_REQ_LOAD,  0,   64'h0, 8'hff, 3, 30, 1, 1, 0, 1, 64'h0000_0000_0000_00AA, 0);

        // reset while a load sits in S1 drops it and the reservation
        applyStimulus(HPDCACHE_REQ_AMO_LR, 9, 64'h0, 8'hff, 3, 31, 1, 1, 0, 1, 64'h0BAD_F00D_0000_0001, 0);
        idle(2);
        applyStimulus(HPDCACHE_REQ_LOAD, 9, 64'h0, 8'hff, 3, 32, 1, 1, 0, 0, 0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rsp_valid_in_reset", rsp_valid_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rsp_valid_after_reset", rsp_valid_o, 1'b0);
        checkOutput("ready_after_reset", req_ready_o, 1'b1);
        applyStimulus(HPDCACHE_REQ_AMO_SC, 9, 64'h5555_5555_5555_5555, 8'hff, 3, 33, 1, 1, 0, 1, 64'h1, 0);
        applyStimulus(HPDCACHE_REQ_LOAD,   9, 64'h0, 8'hff, 3, 34, 1, 1, 0, 1, 64'h0BAD_F00D_0000_0001, 0);

        idle(4);
        checkOutput("queue_drain", 128'(expQ.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpdcache_req_spad_responder.md
Name: hpdcache_req_spad_responder

Overview:
- Responder end of the HPDcache core-request interface.
- Accepts hpdcache_req_t requests (load, store, AMO, LR/SC) plus the deferred tag/abort/PMA side-channel, and serves them from a local 64-bit-word scratchpad.
- Returns hpdcache_rsp_t responses, echoing sid/tid.
- Used as a cache stand-in behind requester adapters, and as a deterministic target for adapter verification.

Parameters:
- DEPTH, 256, number of 64-bit scratchpad words; power of two, at least 2.
- BASE_ADDR, 64'h0, physical byte address of word 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_i  in  hpdcache_req_t  request (addr_offset, addr_tag, wdata, op, be, size, sid, tid, need_rsp, phys_indexed, pma).
- req_abort_i  in  1  kill for a virtually indexed request; sampled the cycle after acceptance.
- req_tag_i  in  hpdcache_tag_t  late tag for a virtually indexed request; sampled the cycle after acceptance.
- req_pma_i  in  hpdcache_pma_t  late PMA; sampled the cycle after acceptance and ignored.
- rsp_valid_o  out  1  response valid; no backpressure.
- rsp_o  out  hpdcache_rsp_t  response: rdata word 0, sid, tid, error.

Behaviour:
- Reset (async): rsp_valid_o=0, rsp_o='0, pipeline empty, reservation invalid, busy=0, so req_ready_o=1 once reset deasserts.
  - Scratchpad contents are not reset.
  - Reset mid-operation drops in-flight requests: no response, no write.
- Handshake: accept in cycle N when req_valid_i && req_ready_o.
  - req_ready_o = !busy.
  - busy is set only in the cycle after an accepted AMO/LR/SC.
- Stage S1, cycle N+1:
  - Address = {addr_tag, addr_offset} if phys_indexed, else {req_tag_i, addr_offset}.
  - If !phys_indexed and req_abort_i=1: request dropped, no side effect, no response.
  - Word index = (addr - BASE_ADDR) >> 3.
  - Out of range (addr < BASE_ADDR or index >= DEPTH): no write; response, if any, has error=1 and rdata=0.
- Load:
  - Array read in S1.
  - rsp_valid_o=1 in N+2 with rdata = full 64-bit word. be is not applied on reads.
- Store:
  - Byte-masked write by be, taking effect at the end of N+1.
  - Response in N+2 only if need_rsp, with rdata=0.
  - A store to the reserved word clears the reservation.
- AMO (SWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU):
  - Read in S1; ALU result written at the end of N+2.
  - Response in N+2 with rdata = old word.
  - size=2: 32-bit operation on the lane selected by be (8'h0f low, 8'hf0 high); wdata carries the operand replicated in both lanes; the other lane is unchanged; MAX/MIN use signed 32-bit compare.
  - size=3: 64-bit operation, be=8'hff.
  - Any AMO to the reserved word clears the reservation.
- LR: sets the reservation (valid, word index); response returns the old word; no write.
- SC:
  - Succeeds if the reservation is valid and the word index matches: write per be, rdata=0.
  - Otherwise: no write, rdata=1.
  - Every SC clears the reservation.
  - An LR/SC/AMO with need_rsp=0 still executes; no response is sent.
- Throughput:
  - Loads and stores: 1 per cycle.
  - Atomics: 1 per 2 cycles, because ready is low in N+1.
- Hazards:
  - Back-to-back store then load to the same word: the load sees the stored data, because the write commits before the load's S1 read.
  - An AMO write in N+2 precedes the next request's S1 read in N+3.
- Any unrecognised op is treated as a load.

Decomposition:
- Shared package hpdcache_spad_pkg holds:
  - spad_word_t (64-bit).
  - spad_idx_t ($clog2(DEPTH)).
  - The reservation struct {valid, idx}.
  - The S1/S2 pipeline register struct {valid, op, idx, be, size, wdata, sid, tid, need_rsp, error}.
- All request, response, tag and PMA types come from hpdcache_pkg.
- One sub-module: hpdcache_spad_amo_alu. It is combinational: old word, operand, op, size, be in; new word out.

Test Plan:
- Physically indexed store of 64'hDEAD_BEEF_0123_4567 (be=ff, need_rsp=0) to word 5, then a load of word 5 (tid=3) -> no response for the store; rsp_valid in N+2 with rdata=64'hDEAD_BEEF_0123_4567 and tid=3.
- Virtually indexed load with req_abort_i=1 in N+1 -> no response and req_ready_o stays 1; an identical load with abort=0 and req_tag_i correct -> response in N+2.
- Word 7 = 64'h0000_0005_FFFF_FFFF; AMO_ADD size=2, be=f0, wdata={2{32'h1}} -> rdata=old word; word 7 becomes 64'h0000_0006_FFFF_FFFF; req_ready_o=0 in N+1.
- LR word 9, store to word 9, SC word 9 -> SC rdata=1 and word unchanged; repeat LR then SC with no intervening store -> rdata=0 and write applied.
- Load of word index DEPTH (out of range) with need_rsp=1 -> error=1, rdata=0; a store to the same index -> no array change.
- Assert rst_i while a load is in S1 -> no rsp_valid_o; after release, req_ready_o=1 and the reservation is invalid (SC returns 1).
